// File: rtl/jtag_types_pkg.sv
// Shared types for the JTAG-side AHB access-point command encoder:
// command word layout, transfer size codes and encoder states.
package jtag_types_pkg;

    localparam int AP_DATA_W = 32;

    localparam logic REGSEL_ADDR = 1'b0;
    localparam logic REGSEL_DATA = 1'b1;

    typedef enum logic [1:0] {
        SZ_BYTE  = 2'b00,
        SZ_HALF  = 2'b01,
        SZ_HALF2 = 2'b10,
        SZ_WORD  = 2'b11
    } ap_size_t;

    // MSB-first: data/address in [40:9], then reg_select, size, len, r_or_w in [0]
    typedef struct packed {
        logic [AP_DATA_W-1:0] data;
        logic                 reg_select;
        ap_size_t             size;
        logic [4:0]           len;
        logic                 r_or_w;
    } ap_cmd_t;

    typedef enum logic [2:0] {
        ENC_IDLE,
        ENC_SEND_ADDR,
        ENC_SEND_DATA,
        ENC_COLLECT,
        ENC_DONE
    } enc_state_t;

endpackage

// File: rtl/ahb_ap_cmd_enc.sv
// Converts one host request into command words for fifo1 and, for reads,
// returns the beats popped from fifo2 to the DR capture logic.
//
// state     | meaning
// IDLE      | accepting a request
// SEND_ADDR | pushing the address word
// SEND_DATA | pushing len+1 write data words
// COLLECT   | forwarding len+1 read beats, watching for a stall
// DONE      | one-cycle completion pulse
module ahb_ap_cmd_enc
    import jtag_types_pkg::*;
#(
    parameter int DATA_W     = 32,
    parameter int CMD_W      = DATA_W + 9,
    parameter int RD_TIMEOUT = 1023
) (
    input  logic              TCK,
    input  logic              TRST,

    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [DATA_W-1:0] req_addr,
    input  logic [1:0]        req_size,
    input  logic [4:0]        req_len,

    input  logic              wbeat_valid,
    output logic              wbeat_ready,
    input  logic [DATA_W-1:0] wbeat_data,

    output logic              resp_valid,
    input  logic              resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_last,

    output logic [CMD_W-1:0]  wdata_fifo1,
    output logic              winc_fifo1,
    input  logic              wfull_fifo1,

    input  logic [DATA_W-1:0] rdata_fifo2,
    output logic              rinc_fifo2,
    input  logic              rempty_fifo2,

    output logic              busy,
    output logic              done,
    output logic              timeout_err
);

    localparam int TMO_W = (RD_TIMEOUT < 1) ? 1 : $clog2(RD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(RD_TIMEOUT - 1);

    enc_state_t        state_q, state_d;
    logic              write_q, write_d;
    logic [DATA_W-1:0] addr_q,  addr_d;
    ap_size_t          size_q,  size_d;
    logic [4:0]        len_q,   len_d;
    logic [4:0]        cnt_q,   cnt_d;
    logic [TMO_W-1:0]  tmo_q,   tmo_d;
    logic              tflag_q, tflag_d;

    logic last_beat;
    logic push;
    logic pop;

    assign last_beat = (cnt_q == len_q);

    always_ff @(posedge TCK or negedge TRST) begin
        if (!TRST) begin
            state_q <= ENC_IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            size_q  <= SZ_BYTE;
            len_q   <= '0;
            cnt_q   <= '0;
            tmo_q   <= '0;
            tflag_q <= 1'b0;
        end else begin
            state_q <= state_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            size_q  <= size_d;
            len_q   <= len_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            tflag_q <= tflag_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        write_d     = write_q;
        addr_d      = addr_q;
        size_d      = size_q;
        len_d       = len_q;
        cnt_d       = cnt_q;
        tmo_d       = '0;
        tflag_d     = tflag_q;
        push        = 1'b0;
        pop         = 1'b0;

        req_ready   = 1'b0;
        wbeat_ready = 1'b0;
        winc_fifo1  = 1'b0;
        wdata_fifo1 = '0;
        resp_valid  = 1'b0;
        resp_data   = '0;
        resp_last   = 1'b0;
        rinc_fifo2  = 1'b0;
        busy        = 1'b1;
        done        = 1'b0;
        timeout_err = 1'b0;

        case (state_q)
            ENC_IDLE: begin
                req_ready = 1'b1;
                busy      = 1'b0;
                tflag_d   = 1'b0;
                if (req_valid) begin
                    write_d = req_write;
                    addr_d  = req_addr;
                    size_d  = ap_size_t'(req_size);
                    len_d   = req_len;
                    cnt_d   = '0;
                    state_d = ENC_SEND_ADDR;
                end
            end

            ENC_SEND_ADDR: begin
                wdata_fifo1 = CMD_W'({addr_q, REGSEL_ADDR, size_q, len_q, write_q});
                push        = !wfull_fifo1;
                winc_fifo1  = push;
                if (push) begin
                    state_d = write_q ? ENC_SEND_DATA : ENC_COLLECT;
                end
            end

            ENC_SEND_DATA: begin
                wbeat_ready = !wfull_fifo1;
                wdata_fifo1 = CMD_W'({wbeat_data, REGSEL_DATA, size_q, len_q, 1'b1});
                push        = wbeat_valid && !wfull_fifo1;
                winc_fifo1  = push;
                if (push) begin
                    if (last_beat) begin
                        state_d = ENC_DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end
            end

            ENC_COLLECT: begin
                resp_valid = !rempty_fifo2;
                resp_data  = rdata_fifo2;
                resp_last  = !rempty_fifo2 && last_beat;
                pop        = !rempty_fifo2 && resp_ready;
                rinc_fifo2 = pop;
                // a pop on the final idle cycle still counts as progress
                if (pop) begin
                    if (last_beat) begin
                        state_d = ENC_DONE;
                    end else begin
                        cnt_d = cnt_q + 5'd1;
                    end
                end else if (tmo_q == TMO_LAST) begin
                    tflag_d = 1'b1;
                    state_d = ENC_DONE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end

            ENC_DONE: begin
                done        = 1'b1;
                timeout_err = tflag_q;
                state_d     = ENC_IDLE;
            end

            default: begin
                state_d = ENC_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_ap_cmd_enc.sv
// Directed and randomized checks of ahb_ap_cmd_enc against a transaction-level
// model of the expected command words and returned read beats.
module tb_ahb_ap_cmd_enc;
    import jtag_types_pkg::*;

    localparam int DATA_W = 32;
    localparam int CMD_W  = 41;
    localparam int RD_TMO = 16;

    logic              TCK = 1'b0;
    logic              TRST;
    logic              req_valid, req_ready, req_write;
    logic [DATA_W-1:0] req_addr;
    logic [1:0]        req_size;
    logic [4:0]        req_len;
    logic              wbeat_valid, wbeat_ready;
    logic [DATA_W-1:0] wbeat_data;
    logic              resp_valid, resp_ready, resp_last;
    logic [DATA_W-1:0] resp_data;
    logic [CMD_W-1:0]  wdata_fifo1;
    logic              winc_fifo1, wfull_fifo1;
    logic [DATA_W-1:0] rdata_fifo2;
    logic              rinc_fifo2, rempty_fifo2;
    logic              busy, done, timeout_err;

    ahb_ap_cmd_enc #(.DATA_W(DATA_W), .CMD_W(CMD_W), .RD_TIMEOUT(RD_TMO)) dut (
        .TCK(TCK), .TRST(TRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_size(req_size), .req_len(req_len),
        .wbeat_valid(wbeat_valid), .wbeat_ready(wbeat_ready), .wbeat_data(wbeat_data),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
        .resp_last(resp_last),
        .wdata_fifo1(wdata_fifo1), .winc_fifo1(winc_fifo1), .wfull_fifo1(wfull_fifo1),
        .rdata_fifo2(rdata_fifo2), .rinc_fifo2(rinc_fifo2), .rempty_fifo2(rempty_fifo2),
        .busy(busy), .done(done), .timeout_err(timeout_err)
    );

    always #5 TCK = ~TCK;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [DATA_W-1:0] wq[$];
    logic [DATA_W-1:0] f2[$];
    logic [CMD_W-1:0]  cap_words[$];
    logic [DATA_W-1:0] cap_resp[$];
    logic              cap_last[$];
    int done_cnt = 0, pop_cnt = 0, done_cyc = 0, first_push_cyc = 0;
    logic last_tmo = 1'b0;

    bit wacc_seen = 0, pop_seen = 0;
    int full_left = 0;
    bit rand_full = 0, rand_valid = 0, rand_ready = 0, rand_stall = 0, ready_toggle = 0;
    bit stall;
    logic [CMD_W-1:0] prev_wdata = '0;
    bit prev_full = 0, prev_busy = 0, prev_push = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic ap_cmd_t mk(input logic [31:0] d, input logic rs, input logic [1:0] sz,
                                   input logic [4:0] ln, input logic rw);
        ap_cmd_t c;
        c.data       = d;
        c.reg_select = rs;
        c.size       = ap_size_t'(sz);
        c.len        = ln;
        c.r_or_w     = rw;
        return c;
    endfunction

    // Monitor: samples mid-cycle what the next rising edge will commit.
    always @(negedge TCK) begin
        cyc++;
        wacc_seen = wbeat_valid && wbeat_ready;
        pop_seen  = rinc_fifo2;
        if (winc_fifo1) begin
            checks++;
            assert (wfull_fifo1 === 1'b0) else begin
                errors++;
                $error("FAIL push_while_full: wfull=%b required 0", wfull_fifo1);
            end
            cap_words.push_back(wdata_fifo1);
            if (cap_words.size() == 1) first_push_cyc = cyc;
        end
        if (rinc_fifo2) begin
            checks++;
            assert (rempty_fifo2 === 1'b0) else begin
                errors++;
                $error("FAIL pop_while_empty: rempty=%b required 0", rempty_fifo2);
            end
            cap_resp.push_back(resp_data);
            cap_last.push_back(resp_last);
            pop_cnt++;
        end
        if (prev_full && prev_busy && busy && !prev_push) begin
            checks++;
            assert (wdata_fifo1 === prev_wdata) else begin
                errors++;
                $error("FAIL wdata_hold: observed %0h expected %0h", wdata_fifo1, prev_wdata);
            end
        end
        if (timeout_err) begin
            checks++;
            assert (done === 1'b1) else begin
                errors++;
                $error("FAIL tmo_without_done: done=%b required 1", done);
            end
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
            last_tmo = timeout_err;
        end
        prev_full  = wfull_fifo1;
        prev_busy  = busy;
        prev_push  = winc_fifo1;
        prev_wdata = wdata_fifo1;
    end

    // Write-beat source and fifo2 model, updated just after each rising edge.
    always @(posedge TCK) begin
        if (wacc_seen && wq.size() > 0) void'(wq.pop_front());
        if (pop_seen && f2.size() > 0) void'(f2.pop_front());
        #1;
        if (full_left > 0) begin
            wfull_fifo1 = 1'b1;
            full_left--;
        end else begin
            wfull_fifo1 = rand_full && ($urandom_range(0, 3) == 0);
        end
        wbeat_valid  = (wq.size() > 0) && (!rand_valid || $urandom_range(0, 2) != 0);
        wbeat_data   = (wq.size() > 0) ? wq[0] : '0;
        stall        = rand_stall && ($urandom_range(0, 7) == 0);
        rempty_fifo2 = (f2.size() == 0) || stall;
        rdata_fifo2  = (f2.size() > 0) ? f2[0] : '0;
        if (ready_toggle) resp_ready = ~resp_ready;
        else              resp_ready = !rand_ready || ($urandom_range(0, 3) != 0);
    end

    task automatic step();
        @(posedge TCK);
        #2;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        int start;
        start = done_cnt;
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            step();
            if (done_cnt > start) begin
                ok = 1;
                break;
            end
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"},   64'(req_ready),   64'(1));
        chk({tag, "_busy"},        64'(busy),        64'(0));
        chk({tag, "_winc"},        64'(winc_fifo1),  64'(0));
        chk({tag, "_rinc"},        64'(rinc_fifo2),  64'(0));
        chk({tag, "_wbeat_ready"}, 64'(wbeat_ready), 64'(0));
        chk({tag, "_resp_valid"},  64'(resp_valid),  64'(0));
        chk({tag, "_resp_last"},   64'(resp_last),   64'(0));
        chk({tag, "_done"},        64'(done),        64'(0));
        chk({tag, "_tmo"},         64'(timeout_err), 64'(0));
        chk({tag, "_wdata"},       64'(wdata_fifo1), 64'(0));
    endtask

    // One transaction: build the expected words/beats, run it, compare.
    task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [1:0] sz,
                           input logic [4:0] ln, input bit tmo_exp, input bit load_f2,
                           input bit fixed, input logic [31:0] d0);
        ap_cmd_t exp_w[$];
        logic [31:0] dat[$];
        bit ok;
        int start, n;
        cap_words.delete(); cap_resp.delete(); cap_last.delete();
        pop_cnt = 0;
        for (int i = 0; i <= int'(ln); i++) dat.push_back(fixed ? d0 * (i + 1) : $urandom);
        exp_w.push_back(mk(addr, REGSEL_ADDR, sz, ln, wr));
        foreach (dat[i]) begin
            if (wr) begin
                exp_w.push_back(mk(dat[i], REGSEL_DATA, sz, ln, 1'b1));
                wq.push_back(dat[i]);
            end else if (load_f2) begin
                f2.push_back(dat[i]);
            end
        end
        chk("req_ready_before", 64'(req_ready), 64'(1));
        start     = done_cnt;
        req_write = wr;
        req_addr  = addr;
        req_size  = sz;
        req_len   = ln;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        wait_done(3000, ok);
        chk("done_seen", 64'(ok), 64'(1));
        chk("timeout_err", 64'(last_tmo), 64'(tmo_exp));
        chk("busy_after", 64'(busy), 64'(0));
        chk("req_ready_after", 64'(req_ready), 64'(1));
        step();
        chk("done_once", 64'(done_cnt - start), 64'(1));
        chk("word_count", 64'(cap_words.size()), 64'(exp_w.size()));
        n = (cap_words.size() < exp_w.size()) ? cap_words.size() : exp_w.size();
        for (int i = 0; i < n; i++) chk("word", 64'(cap_words[i]), {23'b0, exp_w[i]});
        if (!wr) begin
            if (tmo_exp || !load_f2) begin
                chk("no_pop", 64'(pop_cnt), 64'(0));
            end else begin
                chk("beat_count", 64'(cap_resp.size()), 64'(dat.size()));
                n = (cap_resp.size() < dat.size()) ? cap_resp.size() : dat.size();
                for (int i = 0; i < n; i++) begin
                    chk("beat_data", 64'(cap_resp[i]), 64'(dat[i]));
                    chk("beat_last", 64'(cap_last[i]), 64'(i == int'(ln)));
                end
            end
        end
        wq.delete();
        f2.delete();
    endtask

    initial begin
        bit ok;
        logic [31:0] d_a, d_b;
        TRST = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_size = '0; req_len = '0;
        wbeat_valid = 1'b0; wbeat_data = '0; resp_ready = 1'b1;
        wfull_fifo1 = 1'b0; rdata_fifo2 = '0; rempty_fifo2 = 1'b1;
        repeat (3) step();
        chk_reset_outputs("rst");
        TRST = 1'b1;
        step();

        // single write
        run_txn(1'b1, 32'h1000_0000, 2'b11, 5'd0, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF);

        // write burst with fifo1 full for 3 cycles after the first data word
        fork
            run_txn(1'b1, 32'h2000_0040, 2'b11, 5'd3, 1'b0, 1'b0, 0, 0);
            begin
                for (int k = 0; k < 200; k++) begin
                    step();
                    if (cap_words.size() >= 2) break;
                end
                full_left = 3;
            end
        join

        // read burst, consumer ready every other cycle
        ready_toggle = 1;
        run_txn(1'b0, 32'h3000_0000, 2'b11, 5'd2, 1'b0, 1'b1, 1'b1, 32'h11);
        ready_toggle = 0;
        resp_ready = 1'b1;

        // read timeout with fifo2 empty
        run_txn(1'b0, 32'h4000_0000, 2'b01, 5'd2, 1'b1, 1'b0, 0, 0);
        chk("tmo_latency", 64'(done_cyc - first_push_cyc), 64'(RD_TMO + 1));

        // reset in the middle of a write burst
        cap_words.delete();
        for (int i = 0; i < 4; i++) wq.push_back($urandom);
        req_write = 1'b1; req_addr = 32'h5000_0000; req_size = 2'b10; req_len = 5'd3;
        req_valid = 1'b1;
        step();
        req_valid = 1'b0;
        for (int k = 0; k < 100; k++) begin
            if (cap_words.size() >= 3) break;
            step();
        end
        chk("pre_reset_words", 64'(cap_words.size()), 64'(3));
        TRST = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        wq.delete();
        repeat (3) step();
        chk("no_push_after_rst", 64'(cap_words.size()), 64'(3));
        TRST = 1'b1;
        step();
        run_txn(1'b0, 32'h5100_0000, 2'b00, 5'd1, 1'b0, 1'b1, 0, 0);

        // req_valid held through a whole transaction
        cap_words.delete(); cap_resp.delete(); cap_last.delete();
        d_a = $urandom; d_b = $urandom;
        f2.push_back(d_a); f2.push_back(d_b);
        req_write = 1'b0; req_addr = 32'h6000_0000; req_size = 2'b11; req_len = 5'd0;
        req_valid = 1'b1;
        wait_done(200, ok);
        chk("hold_done1", 64'(ok), 64'(1));
        chk("hold_idle_ready", 64'(req_ready), 64'(1));
        chk("hold_idle_busy", 64'(busy), 64'(0));
        chk("hold_words1", 64'(cap_words.size()), 64'(1));
        step();
        chk("hold_reaccept", 64'(busy), 64'(1));
        req_valid = 1'b0;
        wait_done(200, ok);
        chk("hold_done2", 64'(ok), 64'(1));
        chk("hold_words2", 64'(cap_words.size()), 64'(2));
        chk("hold_beats", 64'(cap_resp.size()), 64'(2));
        if (cap_resp.size() == 2) begin
            chk("hold_beat0", 64'(cap_resp[0]), 64'(d_a));
            chk("hold_beat1", 64'(cap_resp[1]), 64'(d_b));
        end
        f2.delete();
        step();

        // randomized traffic with throttling on every interface
        rand_full = 1; rand_valid = 1; rand_ready = 1; rand_stall = 1;
        run_txn(1'b1, $urandom, 2'($urandom), 5'd31, 1'b0, 1'b0, 0, 0);
        run_txn(1'b0, $urandom, 2'($urandom), 5'd31, 1'b0, 1'b1, 0, 0);
        for (int t = 0; t < 14; t++) begin
            run_txn(1'($urandom), $urandom, 2'($urandom), 5'($urandom_range(0, 31)),
                    1'b0, 1'b1, 0, 0);
        end
        rand_full = 0; rand_valid = 0; rand_ready = 0; rand_stall = 0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
